// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the memory loader: FSM state encoding,
// header field positions, and the per-segment word count limit.
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE
    } state_e;

    // Header word layout
    localparam int TARGET_BIT = 31;  // 0 = IM, 1 = DM
    localparam int FINAL_BIT  = 30;  // last segment of the session
    localparam int ADDR_LSB   = 16;  // start word address occupies [26:16]
    localparam int COUNT_MSB  = 11;  // word count occupies [11:0]

    localparam int MAX_WORDS  = 2048;

    // A 12-bit count field can encode up to 4095; anything past the
    // memory depth is clamped so a segment never writes more than once
    // around the address space.
    function automatic logic [COUNT_MSB:0] clamp_count(input logic [COUNT_MSB:0] n);
        return (n > (COUNT_MSB+1)'(MAX_WORDS)) ? (COUNT_MSB+1)'(MAX_WORDS) : n;
    endfunction

endpackage

// File: rtl/memory_loader_if.sv
// -----------------------------------------------------------------------------
// memory_loader_if
// Bundles the byte-stream handshake and the IM/DM load ports.
//   master : loader side (consumes the stream, drives the memory ports)
//   slave  : stream source / processor side
// Signals:
//   in_data/in_valid/in_ready              byte stream, transfer on valid&&ready
//   {im,dm}_{cen,wen,oen}_load             active-low memory controls
//   {im,dm}_addr_load, {im,dm}_datain_load word address and write data
// -----------------------------------------------------------------------------
interface memory_loader_if #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;

    logic                     im_cen_load;
    logic                     im_wen_load;
    logic                     im_oen_load;
    logic [ADDRESS_WIDTH-1:0] im_addr_load;
    logic [DATA_WIDTH-1:0]    im_datain_load;

    logic                     dm_cen_load;
    logic                     dm_wen_load;
    logic                     dm_oen_load;
    logic [ADDRESS_WIDTH-1:0] dm_addr_load;
    logic [DATA_WIDTH-1:0]    dm_datain_load;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load,
        output dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load,
        input  dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load
    );
endinterface

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles little-endian 32-bit words from a byte stream.
//   clk, rst_n     clock, async active-low reset
//   clear_i        drop any partial word and restart at byte 0
//   byte_valid_i   a byte is transferred this cycle
//   byte_i         the byte
//   word_o         assembled word (valid only with word_valid_o)
//   word_valid_o   pulses in the cycle the 4th byte is transferred
// -----------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  cnt_q;
    logic [23:0] sr_q;   // first three bytes; the 4th is taken straight from the input

    // Presenting the word combinationally on the 4th byte lets the loader
    // register the write strobe on that same edge.
    assign word_o       = {byte_i, sr_q};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {byte_i, sr_q[23:8]};  // earlier bytes drift toward [7:0]
        end
    end
endmodule

// File: rtl/memory_loader.sv
// -----------------------------------------------------------------------------
// memory_loader
// Parses a segmented byte stream (header word + N data words) and writes the
// data words into IM or DM through the processor's load port.
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle pulse, begins a session when idle
//   bus          memory_loader_if.master: byte stream + IM/DM load ports
//   loading      session active (processor muxes in the load port)
//   busy         FSM not idle
//   done         one-cycle pulse at session end
// -----------------------------------------------------------------------------
module memory_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    memory_loader_if.master  bus,
    output logic             loading,
    output logic             busy,
    output logic             done
);
    state_e                   state_q, state_d;
    logic                     target_q, target_d;
    logic                     final_q, final_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_MSB:0]       cnt_q, cnt_d;

    logic                     in_ready_q, in_ready_d;
    logic                     loading_q, loading_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     im_cen_q, im_cen_d, im_wen_q, im_wen_d;
    logic                     dm_cen_q, dm_cen_d, dm_wen_q, dm_wen_d;
    logic [ADDRESS_WIDTH-1:0] im_addr_q, im_addr_d, dm_addr_q, dm_addr_d;
    logic [DATA_WIDTH-1:0]    im_data_q, im_data_d, dm_data_q, dm_data_d;

    logic        accept;
    logic [31:0] word;
    logic        word_valid;

    assign accept = bus.in_valid && in_ready_q;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q == IDLE),
        .byte_valid_i (accept),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        final_d   = final_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        im_cen_d  = 1'b1;
        im_wen_d  = 1'b1;
        dm_cen_d  = 1'b1;
        dm_wen_d  = 1'b1;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
        dm_addr_d = dm_addr_q;
        dm_data_d = dm_data_q;

        unique case (state_q)
            IDLE: if (start) state_d = HDR;
            HDR: if (word_valid) begin
                target_d = word[TARGET_BIT];
                final_d  = word[FINAL_BIT];
                addr_d   = word[ADDR_LSB +: ADDRESS_WIDTH];
                cnt_d    = clamp_count(word[COUNT_MSB:0]);
                if (clamp_count(word[COUNT_MSB:0]) == '0)
                    state_d = word[FINAL_BIT] ? DONE : HDR;
                else
                    state_d = DATA;
            end
            // The strobe is registered on the 4th-byte edge, so it is
            // visible to the RAM during the WRITE cycle.
            DATA: if (word_valid) begin
                state_d = WRITE;
                if (target_q) begin
                    dm_cen_d  = 1'b0;
                    dm_wen_d  = 1'b0;
                    dm_addr_d = addr_q;
                    dm_data_d = DATA_WIDTH'(word);
                end else begin
                    im_cen_d  = 1'b0;
                    im_wen_d  = 1'b0;
                    im_addr_d = addr_q;
                    im_data_d = DATA_WIDTH'(word);
                end
            end
            WRITE: begin
                addr_d = addr_q + 1'b1;   // wraps at the memory depth
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == (COUNT_MSB+1)'(1))
                    state_d = final_q ? DONE : HDR;
                else
                    state_d = DATA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        in_ready_d = (state_d == HDR) || (state_d == DATA);
        loading_d  = (state_d == HDR) || (state_d == DATA) || (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= 1'b0;
            final_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            loading_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            im_cen_q   <= 1'b1;
            im_wen_q   <= 1'b1;
            dm_cen_q   <= 1'b1;
            dm_wen_q   <= 1'b1;
            im_addr_q  <= '0;
            im_data_q  <= '0;
            dm_addr_q  <= '0;
            dm_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            final_q    <= final_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            loading_q  <= loading_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            im_cen_q   <= im_cen_d;
            im_wen_q   <= im_wen_d;
            dm_cen_q   <= dm_cen_d;
            dm_wen_q   <= dm_wen_d;
            im_addr_q  <= im_addr_d;
            im_data_q  <= im_data_d;
            dm_addr_q  <= dm_addr_d;
            dm_data_q  <= dm_data_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.im_cen_load    = im_cen_q;
    assign bus.im_wen_load    = im_wen_q;
    assign bus.im_oen_load    = 1'b1;   // the loader never reads
    assign bus.im_addr_load   = im_addr_q;
    assign bus.im_datain_load = im_data_q;
    assign bus.dm_cen_load    = dm_cen_q;
    assign bus.dm_wen_load    = dm_wen_q;
    assign bus.dm_oen_load    = 1'b1;
    assign bus.dm_addr_load   = dm_addr_q;
    assign bus.dm_datain_load = dm_data_q;
    assign loading            = loading_q;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule

// File: tb/tb_memory_loader.sv
module tb_memory_loader;
    typedef struct packed {
        logic        dm;
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic loading, busy, done;

    memory_loader_if #(.ADDRESS_WIDTH(11), .DATA_WIDTH(32)) bus ();

    memory_loader #(.ADDRESS_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .loading (loading),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int          asserts = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          gap_max = 0;
    logic        prev_done = 1'b0;
    logic [31:0] stream[$];
    wr_t         exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_loading",  64'(loading), 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_done",     64'(done), 64'd0);
        check("rst_im_ctl",   64'({bus.im_cen_load, bus.im_wen_load, bus.im_oen_load}), 64'h7);
        check("rst_dm_ctl",   64'({bus.dm_cen_load, bus.dm_wen_load, bus.dm_oen_load}), 64'h7);
        check("rst_im_bus",   64'({bus.im_addr_load, bus.im_datain_load}), 64'd0);
        check("rst_dm_bus",   64'({bus.dm_addr_load, bus.dm_datain_load}), 64'd0);
    endtask

    // Reference model: walk the word stream by the segment rules and list
    // every write that must appear, in order.
    task automatic model_stream();
        int i = 0;
        while (i < stream.size()) begin
            logic [31:0] h;
            int n, a;
            logic dm, fin;
            h   = stream[i];
            i++;
            dm  = h[31];
            fin = h[30];
            a   = int'(h[26:16]);
            n   = int'(h[11:0]);
            if (n > 2048) n = 2048;
            for (int k = 0; k < n; k++) begin
                wr_t e;
                e.dm   = dm;
                e.addr = 11'(a);
                e.data = stream[i];
                exp_q.push_back(e);
                i++;
                a = (a + 1) % 2048;
            end
            if (fin) break;
        end
        exp_done++;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        logic acc;
        g = int'($urandom_range(0, gap_max));
        repeat (g) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) break;
            if (c > 100) begin
                check("byte_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 200 && done_cnt != exp_done; c++) @(posedge clk);
        check("done_count", 64'(done_cnt), 64'(exp_done));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int start_at);
        for (int i = 0; i < stream.size(); i++) begin
            if (i == start_at) pulse_start();  // must be ignored mid-session
            send_word(stream[i]);
        end
    endtask

    // Monitor: every strobe seen on the load ports is matched against the
    // model's expected write list.
    always @(negedge clk) begin
        if (rst_n) begin
            check("im_oen", 64'(bus.im_oen_load), 64'd1);
            check("dm_oen", 64'(bus.dm_oen_load), 64'd1);
            if (!bus.im_cen_load || !bus.dm_cen_load) begin
                check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
                check("single_target", 64'(bus.im_cen_load ^ bus.dm_cen_load), 64'd1);
                if (exp_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL unexpected_write: got im_cen=%0b dm_cen=%0b expected no write",
                             bus.im_cen_load, bus.dm_cen_load);
                end else begin
                    wr_t e, a;
                    e = exp_q.pop_front();
                    a.dm = !bus.dm_cen_load;
                    if (a.dm) begin
                        a.addr = bus.dm_addr_load;
                        a.data = bus.dm_datain_load;
                        check("dm_wen", 64'(bus.dm_wen_load), 64'd0);
                    end else begin
                        a.addr = bus.im_addr_load;
                        a.data = bus.im_datain_load;
                        check("im_wen", 64'(bus.im_wen_load), 64'd0);
                    end
                    check("write", 64'(a), 64'(e));
                end
            end
            if (busy && !done) check("loading_in_session", 64'(loading), 64'd1);
            if (done) begin
                done_cnt++;
                check("loading_at_done", 64'(loading), 64'd0);
                check("done_one_cycle", 64'(prev_done), 64'd0);
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails + 1);
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // Single IM segment with start/write/done timing checks
        stream = '{32'h4003_0002, 32'h8C01_0000, 32'hAC02_0004};
        model_stream();
        pulse_start();
        @(negedge clk);
        check("start_loading", 64'(loading), 64'd1);
        check("start_ready",   64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        run_stream(-1);
        @(negedge clk);
        check("strobe_t1",      64'({bus.im_cen_load, bus.in_ready, bus.dm_cen_load}), 64'b001);
        @(negedge clk);
        check("strobe_released", 64'(bus.im_cen_load), 64'd1);
        check("done_after_write", 64'({done, loading}), 64'b10);
        wait_done();

        // Two segments: IM then DM
        stream = '{32'h0000_0001, 32'h1234_5678, 32'hC010_0001, 32'hDEAD_BEEF};
        model_stream();
        pulse_start();
        run_stream(-1);
        wait_done();

        // Address wrap
        stream = '{32'h47FF_0002, 32'h0BAD_F00D, 32'hCAFE_0001};
        model_stream();
        pulse_start();
        run_stream(-1);
        wait_done();

        // Final header with N = 0
        stream = '{32'h4000_0000};
        model_stream();
        pulse_start();
        run_stream(-1);
        wait_done();

        // Random segments, random gaps, a start pulse mid-session
        gap_max = 3;
        for (int s = 0; s < 6; s++) begin
            int nseg;
            stream.delete();
            nseg = int'($urandom_range(1, 3));
            for (int g = 0; g < nseg; g++) begin
                logic [10:0] a;
                logic [11:0] n;
                logic        dm;
                a  = 11'($urandom);
                n  = 12'($urandom_range(0, 4));
                dm = 1'($urandom);
                stream.push_back({dm, (g == nseg - 1) ? 1'b1 : 1'b0, 3'b0, a, 4'b0, n});
                for (int k = 0; k < int'(n); k++) stream.push_back($urandom);
            end
            model_stream();
            pulse_start();
            run_stream(stream.size() > 3 ? 2 : -1);
            wait_done();
        end
        gap_max = 0;

        // Count field beyond memory depth clamps to 2048
        stream.delete();
        stream.push_back(32'hC005_0FFF);
        for (int k = 0; k < 2048; k++) stream.push_back($urandom);
        model_stream();
        pulse_start();
        run_stream(-1);
        wait_done();

        // Reset after 2 bytes of a data word: no write, reset values
        stream = '{32'h4000_0005};
        pulse_start();
        run_stream(-1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #2;
        check_reset();
        @(negedge clk);
        check_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Session after reset behaves normally
        stream = '{32'hC7FE_0002, 32'h5555_AAAA, 32'h0F0F_F0F0};
        model_stream();
        pulse_start();
        run_stream(-1);
        wait_done();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
